// File: rtl/risc_v_mike_imem_load_arbiter.sv
// Single-port instruction memory arbiter: the core fetch port reads while idle,
// and a program-load session streams words into memory while the core is stalled.
module risc_v_mike_imem_load_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_misalign,
    output logic              core_stall,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_WORDS = (ADDR_W + 1)'(MEM_DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W:0]      cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                rvalid_q, rvalid_d;
    logic                mis_q, mis_d;
    logic [DATA_W-1:0]   hold_q, hold_d;

    logic                gnt_s;
    logic                accept_s;
    logic                last_s;
    logic                bad_base_s;
    logic                range_s;
    logic [ADDR_W:0]     end_idx_s;
    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   ret_data_s;

    // Grant, stall and session-start decode
    always_comb begin
        gnt_s      = fetch_req & (state_q == ST_IDLE);
        accept_s   = (state_q == ST_LOAD) & load_valid;
        last_s     = ((cnt_q + (LEN_W + 1)'(1)) == {1'b0, len_q});
        bad_base_s = (load_base[1:0] != 2'b00);
        // One extra bit keeps base+len from wrapping past the top of the address space
        end_idx_s  = {1'b0, 2'b00, load_base[ADDR_W-1:2]} + (ADDR_W + 1)'(load_len);
        range_s    = (end_idx_s > DEPTH_WORDS);
        wr_addr_s  = base_q + ADDR_W'({cnt_q, 2'b00});
    end

    // Memory port mux: loader writes during an accept, otherwise the fetch address drives reads
    always_comb begin
        if (accept_s) begin
            mem_addr = wr_addr_s;
            mem_we   = 1'b1;
        end else begin
            mem_addr = fetch_addr;
            mem_we   = 1'b0;
        end
        mem_wdata = load_data;
    end

    // Returned instruction word: zero for misaligned fetches, held between returns
    always_comb begin
        if (rvalid_q) begin
            if (mis_q) begin
                ret_data_s = {DATA_W{1'b0}};
            end else begin
                ret_data_s = mem_rdata;
            end
        end else begin
            ret_data_s = hold_q;
        end
    end

    // Next-state logic for the session sequencer and the fetch return pipeline
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        rvalid_d = gnt_s;
        mis_d    = gnt_s & (fetch_addr[1:0] != 2'b00);
        hold_d   = ret_data_s;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (bad_base_s || range_s) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (load_len == {LEN_W{1'b0}}) begin
                        err_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        base_d  = load_base;
                        len_d   = load_len;
                        cnt_d   = {(LEN_W + 1){1'b0}};
                        busy_d  = 1'b1;
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                busy_d = 1'b1;
                if (accept_s) begin
                    cnt_d = cnt_q + (LEN_W + 1)'(1);
                    if (last_s) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            base_q   <= {ADDR_W{1'b0}};
            len_q    <= {LEN_W{1'b0}};
            cnt_q    <= {(LEN_W + 1){1'b0}};
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            hold_q   <= {DATA_W{1'b0}};
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            mis_q    <= mis_d;
            hold_q   <= hold_d;
        end
    end

    assign fetch_gnt      = gnt_s;
    assign core_stall     = (state_q != ST_IDLE) | (fetch_req & ~gnt_s);
    assign fetch_rvalid   = rvalid_q;
    assign fetch_misalign = mis_q;
    assign fetch_rdata    = ret_data_s;
    assign load_ready     = busy_q;
    assign load_busy      = busy_q;
    assign load_done      = done_q;
    assign load_err       = err_q;

endmodule

// File: tb/tb_risc_v_mike_imem_load_arbiter.sv
// Randomized scoreboard bench for the imem load arbiter with a word-array memory model.
module tb_risc_v_mike_imem_load_arbiter;

    localparam int MEM_DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = 32'h0;
    logic        fetch_gnt, fetch_rvalid, fetch_misalign, core_stall;
    logic [31:0] fetch_rdata;
    logic        load_start = 1'b0;
    logic [31:0] load_base = 32'h0;
    logic [15:0] load_len = 16'h0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = 32'h0;
    logic        load_ready, load_busy, load_done, load_err;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata = 32'h0;

    risc_v_mike_imem_load_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(MEM_DEPTH), .LEN_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .fetch_misalign(fetch_misalign), .core_stall(core_stall),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic mis; logic [31:0] data; } fexp_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wexp_t;

    fexp_t       exp_fetch[$];
    wexp_t       exp_wr[$];
    logic        exp_done[$];
    logic [31:0] ref_mem [MEM_DEPTH];
    logic [31:0] tb_mem  [MEM_DEPTH];
    logic [31:0] last_rdata = 32'h0;
    logic        preload = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h0fc10417;
        if (i == 1) return 32'h02440493;
        if (i == 2) return 32'h00f00093;
        return (32'(i) * 32'h9e3779b1) ^ 32'h5a5a0000;
    endfunction

    // Synchronous single-port instruction memory seen by the DUT
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MEM_DEPTH; i++) tb_mem[i] <= init_word(i);
        end else if (mem_we) begin
            tb_mem[mem_addr[11:2]] <= mem_wdata;
        end
        mem_rdata <= tb_mem[mem_addr[11:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a fetch return, a write or a done pulse
    fexp_t fe;
    wexp_t we;
    always @(negedge clk) begin
        if (!rst) begin
            if (fetch_rvalid) begin
                if (exp_fetch.size() == 0) begin
                    check("unexpected_rvalid", fetch_rvalid, 1'b0);
                end else begin
                    fe = exp_fetch.pop_front();
                    check("fetch_misalign", fetch_misalign, fe.mis);
                    check("fetch_rdata", fetch_rdata, fe.data);
                    last_rdata = fe.data;
                end
            end else begin
                check("fetch_rdata_hold", fetch_rdata, last_rdata);
            end
            if (mem_we) begin
                if (exp_wr.size() == 0) begin
                    check("unexpected_write", mem_we, 1'b0);
                end else begin
                    we = exp_wr.pop_front();
                    check("write_addr", mem_addr, we.addr);
                    check("write_data", mem_wdata, we.data);
                end
            end
            if (load_done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", load_done, 1'b0);
                end else begin
                    check("done_err", load_err, exp_done.pop_front());
                end
            end
        end
    end

    function automatic fexp_t fetch_expect(input logic [31:0] a);
        fexp_t f;
        f.mis  = (a[1:0] != 2'b00);
        f.data = f.mis ? 32'h0 : ref_mem[a[11:2]];
        return f;
    endfunction

    task automatic fetch_cycle(input logic req, input logic [31:0] a);
        @(posedge clk); #1;
        fetch_req  = req;
        fetch_addr = a;
        if (req) exp_fetch.push_back(fetch_expect(a));
        @(negedge clk);
        check("fetch_gnt", fetch_gnt, req);
        check("idle_stall", core_stall, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr(input bit allow_mis);
        logic [31:0] a;
        a = {20'h0, 10'($urandom_range(0, MEM_DEPTH - 1)), 2'b00};
        if (allow_mis && $urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    task automatic fetch_burst(input int n);
        for (int i = 0; i < n; i++) fetch_cycle(($urandom_range(0, 3) != 0), rand_addr(1'b1));
        fetch_cycle(1'b0, 32'h0);
    endtask

    // mode 0: load_valid every cycle; 1: pattern 1,0,0,1,1; 2: random gaps, random data, stray load_start
    task automatic do_load(input logic [31:0] base, input int len, input int mode,
                           input logic [31:0] d0, input logic fetch_same);
        logic        err, v;
        logic [4:0]  pat;
        logic [31:0] wd;
        int          cnt, k, idle;
        pat = 5'b11001;
        err = (base[1:0] != 2'b00) ||
              ((longint'(base >> 2) + longint'(len)) > longint'(MEM_DEPTH));
        @(posedge clk); #1;
        load_start = 1'b1;
        load_base  = base;
        load_len   = 16'(len);
        load_valid = 1'b0;
        fetch_req  = fetch_same;
        fetch_addr = rand_addr(1'b0);
        if (fetch_same) exp_fetch.push_back(fetch_expect(fetch_addr));
        @(negedge clk);
        check("start_gnt", fetch_gnt, fetch_same);
        check("start_ready", load_ready, 1'b0);
        @(posedge clk); #1;
        load_start = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = rand_addr(1'b1);
        if (!err && len != 0) begin
            cnt = 0; k = 0; idle = 0;
            while (cnt < len) begin
                if (k > 0) begin
                    @(posedge clk); #1;
                end
                if (mode == 0)      v = 1'b1;
                else if (mode == 1) v = pat[k % 5];
                else                v = ($urandom_range(0, 2) != 0) || (idle >= 4);
                wd = (mode == 2) ? $urandom : d0 + 32'(cnt);
                load_valid = v;
                load_data  = wd;
                fetch_addr = rand_addr(1'b1);
                if (mode == 2) begin
                    load_start = ($urandom_range(0, 3) == 0);
                    load_base  = $urandom;
                    load_len   = 16'($urandom);
                end
                if (v) begin
                    exp_wr.push_back('{addr: base + 32'(4 * cnt), data: wd});
                    ref_mem[(base >> 2) + 32'(cnt)] = wd;
                    cnt++;
                    idle = 0;
                end else begin
                    idle++;
                end
                @(negedge clk);
                check("load_busy", load_busy, 1'b1);
                check("load_ready", load_ready, 1'b1);
                check("load_gnt_blocked", fetch_gnt, 1'b0);
                check("load_stall", core_stall, 1'b1);
                check("load_err_cleared", load_err, 1'b0);
                check("load_done_early", load_done, 1'b0);
                k++;
            end
            @(posedge clk); #1;
            load_valid = 1'b0;
            load_start = 1'b0;
        end
        exp_done.push_back(err);
        @(negedge clk);
        check("done_pulse", load_done, 1'b1);
        check("done_busy", load_busy, 1'b0);
        check("done_ready", load_ready, 1'b0);
        check("done_stall", core_stall, 1'b1);
        check("done_gnt", fetch_gnt, 1'b0);
        check("done_err_value", load_err, err);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        @(negedge clk);
        check("done_cleared", load_done, 1'b0);
        check("err_sticky", load_err, err);
        check("idle_after_done", core_stall, 1'b0);
        if (!err) begin
            for (int i = 0; i < len; i++) fetch_cycle(1'b1, base + 32'(4 * i));
            fetch_cycle(1'b0, 32'h0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rvalid"}, fetch_rvalid, 1'b0);
        check({tag, "_misalign"}, fetch_misalign, 1'b0);
        check({tag, "_rdata"}, fetch_rdata, 32'h0);
        check({tag, "_busy"}, load_busy, 1'b0);
        check({tag, "_ready"}, load_ready, 1'b0);
        check({tag, "_done"}, load_done, 1'b0);
        check({tag, "_err"}, load_err, 1'b0);
        check({tag, "_we"}, mem_we, 1'b0);
        check({tag, "_stall"}, core_stall, 1'b0);
    endtask

    task automatic reset_during_fetch();
        @(posedge clk); #1;
        fetch_req  = 1'b1;
        fetch_addr = 32'h4;
        exp_fetch.push_back(fetch_expect(32'h4));
        @(negedge clk);
        check("rst_fetch_gnt", fetch_gnt, 1'b1);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        rst = 1'b1;
        exp_fetch.delete();
        last_rdata = 32'h0;
        #1;
        check_reset_values("rst_fetch");
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic reset_mid_load();
        @(posedge clk); #1;
        load_start = 1'b1; load_base = 32'h200; load_len = 16'd4; fetch_req = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        load_start = 1'b0; load_valid = 1'b1; load_data = 32'hdeadbeef;
        exp_wr.push_back('{addr: 32'h200, data: 32'hdeadbeef});
        ref_mem[32'h200 >> 2] = 32'hdeadbeef;
        @(negedge clk);
        check("midrst_busy", load_busy, 1'b1);
        @(posedge clk); #1;
        load_valid = 1'b0;
        rst = 1'b1;
        last_rdata = 32'h0;
        #1;
        check_reset_values("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_idle_stall", core_stall, 1'b0);
        fetch_cycle(1'b1, 32'h200);
        fetch_cycle(1'b1, 32'h204);
        fetch_cycle(1'b0, 32'h0);
    endtask

    // Stimulus: directed scenarios followed by randomized sessions and fetch bursts
    initial begin
        logic [31:0] b;
        int          l, kind;
        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        check_reset_values("reset");
        check("reset_gnt", fetch_gnt, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        fetch_cycle(1'b1, 32'h0);
        fetch_cycle(1'b1, 32'h4);
        fetch_cycle(1'b1, 32'h8);
        fetch_cycle(1'b0, 32'h0);

        do_load(32'h10, 3, 0, 32'ha, 1'b0);
        do_load(32'h10, 3, 1, 32'h1a, 1'b1);
        do_load(32'h2, 1, 0, 32'h0, 1'b0);
        do_load(32'h40, 2, 0, 32'h77, 1'b0);
        do_load((MEM_DEPTH - 2) * 4, 2, 0, 32'hc0de0000, 1'b0);
        do_load((MEM_DEPTH - 2) * 4, 3, 0, 32'hbad00000, 1'b0);
        do_load(32'h80, 0, 0, 32'h0, 1'b1);

        fetch_cycle(1'b1, 32'h6);
        fetch_cycle(1'b1, 32'h0);
        fetch_cycle(1'b0, 32'h0);

        for (int it = 0; it < 14; it++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                b = {20'h0, 10'($urandom_range(0, MEM_DEPTH - 1)), 2'($urandom_range(1, 3))};
                l = $urandom_range(1, 4);
            end else if (kind == 1) begin
                b = (MEM_DEPTH - $urandom_range(1, 4)) * 4;
                l = $urandom_range(1, 6);
            end else if (kind == 2) begin
                b = rand_addr(1'b0);
                l = 0;
            end else begin
                b = {20'h0, 10'($urandom_range(0, MEM_DEPTH - 8)), 2'b00};
                l = $urandom_range(1, 6);
            end
            do_load(b, l, 2, 32'h0, $urandom_range(0, 1) == 1);
            fetch_burst(15);
        end

        reset_during_fetch();
        fetch_cycle(1'b1, 32'h8);
        fetch_cycle(1'b0, 32'h0);
        do_load(32'h300, 2, 0, 32'h55, 1'b0);
        reset_mid_load();

        repeat (3) fetch_cycle(1'b0, 32'h0);
        check("fetch_queue_drained", 32'(exp_fetch.size()), 32'h0);
        check("write_queue_drained", 32'(exp_wr.size()), 32'h0);
        check("done_queue_drained", 32'(exp_done.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/risc_v_mike_imem_load_arbiter.md
Name: risc_v_mike_imem_load_arbiter

Overview:
- Owns the single port of the instruction memory and shares it between two users: the core fetch port and a program-load port.
- The program-load port streams 32-bit words into memory while the core is held in stall.
- Sits between the fetch stage, the loader (testbench or boot/debug interface) and the instruction memory.
- Sequences a load session (start, burst of writes, done or error) and returns fetch reads with 1-cycle latency.

Parameters:
- ADDR_W, 32, byte-address width (matches t_pc_addr).
- DATA_W, 32, word width (DATA_32_W).
- MEM_DEPTH, 1024, instruction memory depth in words.
- LEN_W, 16, width of the load length field (in words).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- fetch_req  in  1  core requests an instruction read.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_gnt  out  1  read issued to memory this cycle.
- fetch_rvalid  out  1  fetch_rdata valid (1 cycle after grant).
- fetch_rdata  out  DATA_W  instruction word.
- fetch_misalign  out  1  returned fetch had addr[1:0]!=0.
- core_stall  out  1  core must hold its PC.
- load_start  in  1  start a load session (pulse).
- load_base  in  ADDR_W  byte base address of the session.
- load_len  in  LEN_W  number of words to write.
- load_valid  in  1  load_data valid.
- load_data  in  DATA_W  word to write.
- load_ready  out  1  arbiter accepts load_data.
- load_busy  out  1  session in progress.
- load_done  out  1  1-cycle pulse at end of session.
- load_err  out  1  sticky error of the last session.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, synchronous, valid the cycle after mem_addr with mem_we=0.

Behaviour:
- Reset values:
  - State IDLE; word counter 0.
  - fetch_rvalid, fetch_misalign, load_busy, load_done, load_err, mem_we all 0.
  - fetch_rdata 0.
- FSM states:
  - IDLE: fetch owns memory.
  - LOAD: loader owns memory.
  - DONE: 1 cycle, load_done=1, then IDLE.
- Grant and stall:
  - fetch_gnt = fetch_req & state==IDLE (combinational).
  - mem_addr = fetch_addr on grant; mem_we=0.
  - core_stall = state!=IDLE | (fetch_req & !fetch_gnt).
- Fetch return:
  - fetch_rvalid is registered fetch_gnt; fetch_rdata = mem_rdata in that cycle.
  - fetch_misalign is the registered |fetch_addr[1:0] of the granted request.
  - When misaligned, fetch_rdata = 0 (NOP-safe).
  - fetch_rdata holds its last value when fetch_rvalid=0.
- Session start (IDLE, load_start=1):
  - load_err clears, then one of:
    - load_base[1:0]!=0, or (load_base>>2)+load_len > MEM_DEPTH: load_err=1, no writes, go to DONE.
    - load_len==0: no writes, go to DONE, load_err=0.
    - Otherwise: latch base word index and length, counter=0, go to LOAD.
  - A fetch requested in the same cycle is still granted; LOAD begins the next cycle.
- LOAD:
  - load_busy=1, load_ready=1.
  - On load_valid & load_ready: mem_we=1, mem_addr=base+4*counter, mem_wdata=load_data (combinational from the inputs), counter++.
  - The accept with counter==len-1 goes to DONE.
  - load_valid=0 idles without a write; no timeout.
- load_ready=0 outside LOAD.
- load_start outside IDLE is ignored.
- Counter is LEN_W+1 bits; the end-of-range check is done in ADDR_W+1 bits to avoid wrap.
- Reset mid-session:
  - Returns to IDLE immediately; in-flight fetch_rvalid is dropped.
  - Words already written stay in memory (memory is not reset by this block).

Test Plan:
- Reset, fetch_req=1, addr 0,4,8 back-to-back, memory preloaded 0x0fc10417/0x02440493/0x00f00093 -> fetch_gnt every cycle; fetch_rvalid 1 cycle later with those words in order; core_stall=0.
- load_start base=0x10 len=3, load_valid every cycle with 0xA,0xB,0xC -> writes to 0x10/0x14/0x18; load_busy 3 cycles; load_done pulse next cycle; fetch_req blocked with core_stall=1 throughout.
- Same load with load_valid gaps (1,0,0,1,1) -> exactly 3 writes at consecutive addresses; no write on gap cycles; load_done after the 3rd accept.
- load_start base=0x2 len=1 -> no mem_we, load_done pulse, load_err=1; a following good load clears load_err.
- Boundary: base=(MEM_DEPTH-2)*4 len=2 -> accepted, writes 2 words. base=(MEM_DEPTH-2)*4 len=3 -> load_err=1, no writes. len=0 -> done, no error.
- fetch_addr=0x6 -> fetch_rvalid with fetch_misalign=1, fetch_rdata=0. Assert rst during LOAD after 1 of 4 words -> all outputs at reset values; FSM back in IDLE; next fetch granted.
